// File: rtl/stack_pkg.sv
// Shared stack constants and types.
// Used by the pointer controller and the datapath.
package stack_pkg;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    typedef logic [DW-1:0] stack_word_t;
    typedef logic [AW-1:0] stack_addr_t;
endpackage

// File: rtl/stack_datapath_if.sv
// Bundle between controller/driver and the stack datapath.
// Slave side is the datapath.
interface stack_datapath_if;
    import stack_pkg::*;

    logic        push;
    logic        pop;
    stack_word_t din;
    stack_addr_t addr;
    logic        wen;
    logic        empty;
    logic        full;
    logic        err_clr;
    stack_word_t dout;
    logic        dout_valid;
    stack_word_t top_data;
    logic        top_valid;
    logic        ovf_err;
    logic        unf_err;

    modport slave (
        input  push, pop, din, addr, wen, empty, full, err_clr,
        output dout, dout_valid, top_data, top_valid, ovf_err, unf_err
    );

    modport master (
        output push, pop, din, addr, wen, empty, full, err_clr,
        input  dout, dout_valid, top_data, top_valid, ovf_err, unf_err
    );
endinterface

// File: rtl/stack_regfile.sv
// DEPTH x DW storage, one sync write port, one async read port.
// Contents are intentionally not reset.
module stack_regfile
    import stack_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  stack_addr_t waddr,
    input  stack_word_t wdata,
    input  stack_addr_t raddr,
    output stack_word_t rdata
);
    stack_word_t mem_q [DEPTH];

    // Write the addressed entry when the controller enables it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/stack_datapath.sv
// Stack storage stage: push capture, forwarded read, pop output
// and sticky overflow/underflow flags.
module stack_datapath
    import stack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    stack_datapath_if.slave bus
);
    stack_word_t din_q, din_d;
    stack_word_t dout_q, dout_d;
    logic        dv_q, dv_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    stack_word_t mem_rd;
    stack_word_t rd;
    logic        push_ok;
    logic        pop_ok;
    logic        ovf_evt;
    logic        unf_evt;

    assign push_ok = bus.push & ~bus.full;
    assign pop_ok  = bus.pop & ~bus.push & ~bus.empty;
    assign ovf_evt = bus.push & bus.full;
    assign unf_evt = bus.pop & ~bus.push & bus.empty;

    stack_regfile u_rf (
        .clk   (clk),
        .we    (bus.wen),
        .waddr (bus.addr),
        .wdata (din_q),
        .raddr (bus.addr),
        .rdata (mem_rd)
    );

    // Pending write is not yet in the array, so forward it.
    assign rd = bus.wen ? din_q : mem_rd;

    // Next-state for push staging, pop output and error flags.
    always_comb begin
        din_d  = din_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (push_ok) begin
            din_d = bus.din;
        end
        if (pop_ok) begin
            dout_d = rd;
            dv_d   = 1'b1;
        end
        ovf_d = (ovf_q & ~bus.err_clr) | ovf_evt;
        unf_d = (unf_q & ~bus.err_clr) | unf_evt;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            din_q  <= din_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.top_data   = rd;
    assign bus.top_valid  = ~bus.empty;
    assign bus.ovf_err    = ovf_q;
    assign bus.unf_err    = unf_q;
endmodule

// File: tb/tb_stack_datapath.sv
// Directed bench for stack_datapath with a small
// stack pointer controller model driving addr/wen/empty/full.
module tb_stack_datapath;
    import stack_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cnt;

    stack_datapath_if bus ();

    stack_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller model: registered top index, write enable and flags.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 0;
            bus.addr  <= '0;
            bus.wen   <= 1'b0;
            bus.empty <= 1'b1;
            bus.full  <= 1'b0;
        end else if (bus.push && cnt != DEPTH) begin
            cnt       <= cnt + 1;
            bus.addr  <= stack_addr_t'(cnt);
            bus.wen   <= 1'b1;
            bus.empty <= 1'b0;
            bus.full  <= (cnt == DEPTH - 1);
        end else if (bus.pop && cnt != 0) begin
            cnt       <= cnt - 1;
            bus.addr  <= (cnt >= 2) ? stack_addr_t'(cnt - 2) : '0;
            bus.wen   <= 1'b0;
            bus.empty <= (cnt == 1);
            bus.full  <= 1'b0;
        end else begin
            bus.wen   <= 1'b0;
        end
    end

    task automatic drive(input logic p, input logic q,
                         input stack_word_t d, input logic c);
        bus.push    = p;
        bus.pop     = q;
        bus.din     = d;
        bus.err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.err_clr = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dout got %h/%b exp 00/0",
                     bus.dout, bus.dout_valid);
        end
        n_vec++;
        if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err got %b/%b exp 0/0",
                     bus.ovf_err, bus.unf_err);
        end
        n_vec++;
        if (bus.top_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_top_valid got %b exp 0", bus.top_valid);
        end
        rst = 1'b1;
    endtask

    task automatic test_lifo();
        stack_word_t exp_q [3];
        exp_q[0] = 8'h33;
        exp_q[1] = 8'h22;
        exp_q[2] = 8'h11;
        drive(1, 0, 8'h11, 0);
        drive(1, 0, 8'h22, 0);
        drive(1, 0, 8'h33, 0);
        drive(0, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0);
        n_vec++;
        if (bus.top_data !== 8'h33 || bus.top_valid !== 1'b1) begin
            n_err++;
            $display("FAIL lifo_top got %h/%b exp 33/1",
                     bus.top_data, bus.top_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'h00, 0);
            n_vec++;
            if (bus.dout !== exp_q[i] || bus.dout_valid !== 1'b1) begin
                n_err++;
                $display("FAIL lifo_pop%0d got %h/%b exp %h/1",
                         i, bus.dout, bus.dout_valid, exp_q[i]);
            end
        end
        drive(0, 0, 8'h00, 0);
        n_vec++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h11) begin
            n_err++;
            $display("FAIL lifo_idle got %h/%b exp 11/0",
                     bus.dout, bus.dout_valid);
        end
        n_vec++;
        if (bus.top_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lifo_empty got %b exp 0", bus.top_valid);
        end
    endtask

    task automatic test_forward();
        drive(1, 0, 8'hA5, 0);
        drive(0, 1, 8'h00, 0);
        n_vec++;
        if (bus.dout !== 8'hA5 || bus.dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fwd_pop got %h/%b exp a5/1",
                     bus.dout, bus.dout_valid);
        end
        n_vec++;
        if (dut.u_rf.mem_q[0] !== 8'hA5) begin
            n_err++;
            $display("FAIL fwd_write got %h exp a5", dut.u_rf.mem_q[0]);
        end
        drive(0, 0, 8'h00, 0);
        n_vec++;
        if (bus.top_valid !== 1'b0 || bus.dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_after got %b/%b exp 0/0",
                     bus.top_valid, bus.dout_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, stack_word_t'(i), 0);
        end
        drive(1, 0, 8'hFF, 0);
        n_vec++;
        if (bus.ovf_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set got %b exp 1", bus.ovf_err);
        end
        n_vec++;
        if (bus.top_data !== 8'h08) begin
            n_err++;
            $display("FAIL ovf_top got %h exp 08", bus.top_data);
        end
        drive(0, 0, 8'h00, 0);
        n_vec++;
        if (bus.top_data !== 8'h08 || dut.din_q !== 8'h08) begin
            n_err++;
            $display("FAIL ovf_nowrite got %h/%h exp 08/08",
                     bus.top_data, dut.din_q);
        end
        for (int i = 8; i >= 1; i--) begin
            drive(0, 1, 8'h00, 0);
            n_vec++;
            if (bus.dout !== stack_word_t'(i) || bus.dout_valid !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_pop%0d got %h/%b exp %h/1",
                         i, bus.dout, bus.dout_valid, stack_word_t'(i));
            end
        end
        drive(0, 0, 8'h00, 1);
        n_vec++;
        if (bus.ovf_err !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr got %b exp 0", bus.ovf_err);
        end
    endtask

    task automatic test_underflow();
        drive(0, 1, 8'h00, 0);
        n_vec++;
        if (bus.unf_err !== 1'b1 || bus.dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL unf_set got %b/%b exp 1/0",
                     bus.unf_err, bus.dout_valid);
        end
        n_vec++;
        if (bus.dout !== 8'h01) begin
            n_err++;
            $display("FAIL unf_dout got %h exp 01", bus.dout);
        end
        drive(0, 1, 8'h00, 1);
        n_vec++;
        if (bus.unf_err !== 1'b1) begin
            n_err++;
            $display("FAIL unf_setwins got %b exp 1", bus.unf_err);
        end
        drive(0, 0, 8'h00, 1);
        n_vec++;
        if (bus.unf_err !== 1'b0 || bus.ovf_err !== 1'b0) begin
            n_err++;
            $display("FAIL unf_clr got %b/%b exp 0/0",
                     bus.unf_err, bus.ovf_err);
        end
    endtask

    task automatic test_push_pop();
        drive(1, 0, 8'h40, 0);
        drive(1, 1, 8'h5C, 0);
        n_vec++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h01) begin
            n_err++;
            $display("FAIL pp_nopop got %h/%b exp 01/0",
                     bus.dout, bus.dout_valid);
        end
        drive(0, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0);
        n_vec++;
        if (bus.top_data !== 8'h5C) begin
            n_err++;
            $display("FAIL pp_top got %h exp 5c", bus.top_data);
        end
        drive(0, 1, 8'h00, 0);
        n_vec++;
        if (bus.dout !== 8'h5C || bus.dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pp_pop1 got %h/%b exp 5c/1",
                     bus.dout, bus.dout_valid);
        end
        drive(0, 1, 8'h00, 0);
        n_vec++;
        if (bus.dout !== 8'h40 || bus.dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pp_pop2 got %h/%b exp 40/1",
                     bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 8'h00, 0);
        drive(1, 0, 8'h77, 0);
        drive(0, 1, 8'h00, 0);
        n_vec++;
        if (bus.dout !== 8'h77 || bus.dout_valid !== 1'b1 ||
            bus.unf_err !== 1'b1) begin
            n_err++;
            $display("FAIL ar_pre got %h/%b/%b exp 77/1/1",
                     bus.dout, bus.dout_valid, bus.unf_err);
        end
        bus.pop = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ar_dout got %h/%b exp 00/0",
                     bus.dout, bus.dout_valid);
        end
        n_vec++;
        if (bus.unf_err !== 1'b0 || bus.ovf_err !== 1'b0 ||
            dut.din_q !== 8'h00) begin
            n_err++;
            $display("FAIL ar_err got %b/%b/%h exp 0/0/00",
                     bus.unf_err, bus.ovf_err, dut.din_q);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 8'h00, 0);
        n_vec++;
        if (bus.dout_valid !== 1'b0 || bus.top_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ar_post got %b/%b exp 0/0",
                     bus.dout_valid, bus.top_valid);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_lifo();
        test_forward();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
